vctr_frame_parser: RTL and testbench

VCTR_FRAME_PARSER -- requirements
Module: vctr_frame_parser

---
 rtl/vctr_pkg.sv | 20 ++
 rtl/vctr_frame_parser_if.sv | 23 ++
 rtl/vctr_byte_ram.sv | 29 ++
 rtl/vctr_frame_parser.sv | 162 ++++++++++++++++
 tb/tb_vctr_frame_parser.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/vctr_pkg.sv
// Shared definitions for the vctr frame parser: FSM encoding, default
// start-of-frame byte and the length check used by the LEN state.
package vctr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_DRAIN   = 3'd4
  } vctr_state_e;

  localparam logic [7:0] VCTR_HDR_DEFAULT = 8'hA5;

  // A length byte is usable when it names at least one byte and fits the buffer.
  function automatic logic vctr_len_ok(input logic [7:0] len, input logic [7:0] max_len);
    return (len != 8'h00) && (len <= max_len);
  endfunction

endpackage

// File: rtl/vctr_frame_parser_if.sv
// Byte-level bus between the UART rx stage, the frame parser and the
// vector-out stage, plus the parser's status strobes.
interface vctr_frame_parser_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       frame_ok;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output rx_byte, rx_valid, out_ready,
    input  out_data, out_valid, frame_ok, frame_err, overrun, busy
  );

  modport slave (
    input  rx_byte, rx_valid, out_ready,
    output out_data, out_valid, frame_ok, frame_err, overrun, busy
  );
endinterface

// File: rtl/vctr_byte_ram.sv
// Payload store: DEPTH x 8 bits, synchronous write, combinational read.
// Contents are deliberately not reset.
module vctr_byte_ram #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we && (waddr < DEPTH_A)) begin
      mem[IW'(waddr)] <= wdata;
    end
  end

  // Out-of-range reads return zero rather than X.
  assign rdata = (raddr < DEPTH_A) ? mem[IW'(raddr)] : 8'h00;

endmodule

// File: rtl/vctr_frame_parser.sv
// Parses HDR / length / payload / xor-checksum frames from a UART byte
// stream and replays accepted payloads to a ready/valid downstream stage.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | waiting for the HDR byte, everything else ignored
// ST_LEN     | next byte is the payload length
// ST_PAYLOAD | storing payload bytes, folding them into the checksum
// ST_CHK     | next byte is compared against the running checksum
// ST_DRAIN   | replaying the buffer downstream; rx bytes are dropped
module vctr_frame_parser
  import vctr_pkg::*;
#(
  parameter int         MAX_LEN = 8,
  parameter logic [7:0] HDR     = VCTR_HDR_DEFAULT,
  parameter int         TIMEOUT = 1000
) (
  input logic                 clock,
  input logic                 nrst,
  vctr_frame_parser_if.slave  bus
);

  localparam int              IDX_W     = $clog2(MAX_LEN + 1);
  localparam int              TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);

  vctr_state_e       state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        chk_q, chk_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  rd_q, rd_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic              ram_we;
  logic [7:0]        ram_rdata;
  logic              ok_c, err_c, ovr_c;
  logic [7:0]        idx_ext, rd_ext;

  assign idx_ext = 8'(idx_q);
  assign rd_ext  = 8'(rd_q);

  vctr_byte_ram #(
    .DEPTH (MAX_LEN),
    .AW    (IDX_W)
  ) u_byte_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (idx_q),
    .wdata (bus.rx_byte),
    .raddr (rd_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      chk_q   <= '0;
      idx_q   <= '0;
      rd_q    <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      chk_q   <= chk_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    chk_d   = chk_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    tmo_d   = tmo_q;
    ram_we  = 1'b0;
    ok_c    = 1'b0;
    err_c   = 1'b0;
    ovr_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.rx_valid && (bus.rx_byte == HDR)) begin
          state_d = ST_LEN;
          tmo_d   = TMO_LOAD;
          idx_d   = '0;
          rd_d    = '0;
          chk_d   = '0;
        end
      end

      ST_LEN, ST_PAYLOAD, ST_CHK: begin
        if (bus.rx_valid) begin
          tmo_d = TMO_LOAD;
          // HDR-valued bytes land here as ordinary data, never as a resync.
          case (state_q)
            ST_LEN: begin
              if (vctr_len_ok(bus.rx_byte, MAX_LEN_B)) begin
                len_d   = bus.rx_byte;
                chk_d   = bus.rx_byte;
                state_d = ST_PAYLOAD;
              end else begin
                err_c   = 1'b1;
                state_d = ST_IDLE;
              end
            end
            ST_PAYLOAD: begin
              ram_we = 1'b1;
              chk_d  = chk_q ^ bus.rx_byte;
              idx_d  = idx_q + IDX_W'(1);
              if ((idx_ext + 8'd1) == len_q) begin
                state_d = ST_CHK;
              end
            end
            default: begin
              if (bus.rx_byte == chk_q) begin
                ok_c    = 1'b1;
                rd_d    = '0;
                state_d = ST_DRAIN;
              end else begin
                err_c   = 1'b1;
                state_d = ST_IDLE;
              end
            end
          endcase
        end else if (tmo_q == '0) begin
          err_c   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end

      ST_DRAIN: begin
        ovr_c = bus.rx_valid;
        if (bus.out_ready) begin
          rd_d = rd_q + IDX_W'(1);
          if ((rd_ext + 8'd1) == len_q) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Everything visible is forced quiet while nrst is low, even before the first edge.
  assign bus.out_valid = nrst && (state_q == ST_DRAIN);
  assign bus.out_data  = bus.out_valid ? ram_rdata : 8'h00;
  assign bus.frame_ok  = nrst && ok_c;
  assign bus.frame_err = nrst && err_c;
  assign bus.overrun   = nrst && ovr_c;
  assign bus.busy      = nrst && (state_q != ST_IDLE);

endmodule

// File: tb/tb_vctr_frame_parser.sv
// Directed vector bench for vctr_frame_parser: one record per clock with
// inputs and the outputs expected during that clock.
module tb_vctr_frame_parser;
  import vctr_pkg::*;

  localparam int TMO = 1000;

  typedef struct {
    logic       n;
    logic       v;
    logic [7:0] b;
    logic       rdy;
    logic       ov;
    logic [7:0] od;
    logic       ok;
    logic       er;
    logic       orun;
    logic       busy;
  } vec_t;

  logic clock = 1'b0;
  logic nrst  = 1'b0;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];

  vctr_frame_parser_if bus ();

  vctr_frame_parser #(
    .MAX_LEN (8),
    .HDR     (8'hA5),
    .TIMEOUT (TMO)
  ) dut (
    .clock (clock),
    .nrst  (nrst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input logic n, input logic v, input logic [7:0] b, input logic rdy,
                              input logic ov, input logic [7:0] od, input logic ok,
                              input logic er, input logic orun, input logic busy);
    vec_t t;
    t.n = n; t.v = v; t.b = b; t.rdy = rdy;
    t.ov = ov; t.od = od; t.ok = ok; t.er = er; t.orun = orun; t.busy = busy;
    return t;
  endfunction

  // Drive one cycle's inputs just after a falling edge, sample just before the rising edge.
  task automatic apply(input vec_t t, input string name);
    logic [12:0] got, exp;
    nrst         = t.n;
    bus.rx_valid = t.v;
    bus.rx_byte  = t.b;
    bus.out_ready = t.rdy;
    #4;
    got = {bus.out_valid, bus.out_data, bus.frame_ok, bus.frame_err, bus.overrun, bus.busy};
    exp = {t.ov, t.od, t.ok, t.er, t.orun, t.busy};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got ov=%b od=%h ok=%b er=%b orun=%b busy=%b, want ov=%b od=%h ok=%b er=%b orun=%b busy=%b",
               name, got[12], got[11:4], got[3], got[2], got[1], got[0],
               t.ov, t.od, t.ok, t.er, t.orun, t.busy);
    end
    @(negedge clock);
  endtask

  // Plain data byte in a busy state with nothing else expected.
  function automatic vec_t rx_busy(input logic [7:0] b);
    return mk(1, 1, b, 1, 0, 8'h00, 0, 0, 0, 1);
  endfunction

  function automatic vec_t rx_idle(input logic [7:0] b);
    return mk(1, 1, b, 1, 0, 8'h00, 0, 0, 0, 0);
  endfunction

  function automatic vec_t quiet();
    return mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0);
  endfunction

  function automatic vec_t drain(input logic [7:0] od);
    return mk(1, 0, 8'h00, 1, 1, od, 0, 0, 0, 1);
  endfunction

  initial begin
    bus.rx_valid  = 1'b0;
    bus.rx_byte   = 8'h00;
    bus.out_ready = 1'b1;

    // reset: all outputs quiet, a HDR during reset starts nothing
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 8'hA5, 1, 0, 8'h00, 0, 0, 0, 0));
    vecs.push_back(quiet());

    // good frame A5 03 11 22 33 03
    vecs.push_back(rx_idle(8'hA5));
    vecs.push_back(rx_busy(8'h03));
    vecs.push_back(rx_busy(8'h11));
    vecs.push_back(rx_busy(8'h22));
    vecs.push_back(rx_busy(8'h33));
    vecs.push_back(mk(1, 1, 8'h03, 1, 0, 8'h00, 1, 0, 0, 1));
    vecs.push_back(drain(8'h11));
    vecs.push_back(drain(8'h22));
    vecs.push_back(drain(8'h33));
    vecs.push_back(quiet());

    // bad checksum A5 02 10 20 31 (expected 32)
    vecs.push_back(rx_idle(8'hA5));
    vecs.push_back(rx_busy(8'h02));
    vecs.push_back(rx_busy(8'h10));
    vecs.push_back(rx_busy(8'h20));
    vecs.push_back(mk(1, 1, 8'h31, 1, 0, 8'h00, 0, 1, 0, 1));
    vecs.push_back(quiet());

    // bad lengths 00 and 09, then a good 1-byte frame
    vecs.push_back(rx_idle(8'hA5));
    vecs.push_back(mk(1, 1, 8'h00, 1, 0, 8'h00, 0, 1, 0, 1));
    vecs.push_back(quiet());
    vecs.push_back(rx_idle(8'hA5));
    vecs.push_back(mk(1, 1, 8'h09, 1, 0, 8'h00, 0, 1, 0, 1));
    vecs.push_back(quiet());
    vecs.push_back(rx_idle(8'hA5));
    vecs.push_back(rx_busy(8'h01));
    vecs.push_back(rx_busy(8'h7E));
    vecs.push_back(mk(1, 1, 8'h7F, 1, 0, 8'h00, 1, 0, 0, 1));
    vecs.push_back(drain(8'h7E));
    vecs.push_back(quiet());

    // HDR value inside the payload is data: A5 02 A5 A5 02
    vecs.push_back(rx_idle(8'hA5));
    vecs.push_back(rx_busy(8'h02));
    vecs.push_back(rx_busy(8'hA5));
    vecs.push_back(rx_busy(8'hA5));
    vecs.push_back(mk(1, 1, 8'h02, 1, 0, 8'h00, 1, 0, 0, 1));
    vecs.push_back(drain(8'hA5));
    vecs.push_back(drain(8'hA5));
    vecs.push_back(quiet());

    // backpressure: A5 02 C3 3C FD, out_ready low 5 cycles with rx traffic
    vecs.push_back(rx_idle(8'hA5));
    vecs.push_back(rx_busy(8'h02));
    vecs.push_back(rx_busy(8'hC3));
    vecs.push_back(rx_busy(8'h3C));
    vecs.push_back(mk(1, 1, 8'hFD, 1, 0, 8'h00, 1, 0, 0, 1));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 1, 8'h55, 0, 1, 8'hC3, 0, 0, 1, 1));
    vecs.push_back(drain(8'hC3));
    // HDR on the last DRAIN cycle is dropped; the one after starts a frame
    vecs.push_back(mk(1, 1, 8'hA5, 1, 1, 8'h3C, 0, 0, 1, 1));
    vecs.push_back(rx_idle(8'hA5));
    vecs.push_back(rx_busy(8'h01));
    vecs.push_back(rx_busy(8'h44));
    vecs.push_back(mk(1, 1, 8'h45, 1, 0, 8'h00, 1, 0, 0, 1));
    vecs.push_back(drain(8'h44));
    vecs.push_back(quiet());

    @(negedge clock);
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec[%0d]", i));

    // timeout: A5 04 AA then silence; frame_err on exactly the TMO-th idle clock
    apply(rx_idle(8'hA5), "tmo_hdr");
    apply(rx_busy(8'h04), "tmo_len");
    apply(rx_busy(8'hAA), "tmo_data");
    for (int k = 1; k <= TMO; k++) begin
      apply(mk(1, 0, 8'h00, 1, 0, 8'h00, 0, (k == TMO), 0, 1), $sformatf("tmo_wait[%0d]", k));
    end
    apply(quiet(), "tmo_after");

    // reset mid-PAYLOAD, then a clean frame A5 01 5A 5B
    apply(rx_idle(8'hA5), "rst_hdr");
    apply(rx_busy(8'h03), "rst_len");
    apply(rx_busy(8'h11), "rst_data");
    apply(mk(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0), "rst_low");
    apply(quiet(), "rst_after");
    apply(quiet(), "rst_after2");
    apply(rx_idle(8'hA5), "post_hdr");
    apply(rx_busy(8'h01), "post_len");
    apply(rx_busy(8'h5A), "post_data");
    apply(mk(1, 1, 8'h5B, 1, 0, 8'h00, 1, 0, 0, 1), "post_chk");
    apply(drain(8'h5A), "post_drain");
    apply(quiet(), "post_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
